// File: rtl/bram_dp_if.sv
// bram_dp_if: one access port of bram_dp. Holds enable, byte write enables, address,
// write data, and the returned read data and valid strobe.
interface bram_dp_if #(
  parameter int p_RAM_WIDTH  = 32,
  parameter int p_RAM_DEPTH  = 1024,
  parameter int p_BYTE_WIDTH = 8
);
  localparam int NB = p_RAM_WIDTH / p_BYTE_WIDTH;
  localparam int AW = (p_RAM_DEPTH > 1) ? $clog2(p_RAM_DEPTH) : 1;

  logic                   i_en;
  logic [NB-1:0]          in_we;
  logic [AW-1:0]          in_addr;
  logic [p_RAM_WIDTH-1:0] in_din;
  logic [p_RAM_WIDTH-1:0] on_dout;
  logic                   o_valid;

  modport master (output i_en, in_we, in_addr, in_din, input  on_dout, o_valid);
  modport slave  (input  i_en, in_we, in_addr, in_din, output on_dout, o_valid);
endinterface

// File: rtl/bram_dp.sv
// bram_dp: true dual-port block RAM with byte write enables and a selectable write mode.
// Define BRAM_DP_OUTREG_EN to add the BRAM DOUT register stage (read latency 2 instead of 1).
module bram_dp #(
  parameter int p_RAM_WIDTH  = 32,
  parameter int p_RAM_DEPTH  = 1024,
  parameter int p_BYTE_WIDTH = 8,
  parameter int p_WRITE_MODE = 0
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  bram_dp_if.slave port_a,
  bram_dp_if.slave port_b
);
  localparam int NB = p_RAM_WIDTH / p_BYTE_WIDTH;
  localparam int AW = (p_RAM_DEPTH > 1) ? $clog2(p_RAM_DEPTH) : 1;
  localparam int BW = p_BYTE_WIDTH;

  localparam int MODE_WRITE_FIRST = 0;
  localparam int MODE_READ_FIRST  = 1;
  localparam int MODE_NO_CHANGE   = 2;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                   en;
  logic [1:0][NB-1:0]           we;
  logic [1:0][AW-1:0]           addr;
  logic [1:0][p_RAM_WIDTH-1:0]  din;
  logic [1:0]                   in_range;
  logic [1:0]                   updates;
  logic [1:0][p_RAM_WIDTH-1:0]  dout_q;
  logic [1:0]                   valid_q;

  assign en[0]   = port_a.i_en;
  assign we[0]   = port_a.in_we;
  assign addr[0] = port_a.in_addr;
  assign din[0]  = port_a.in_din;
  assign en[1]   = port_b.i_en;
  assign we[1]   = port_b.in_we;
  assign addr[1] = port_b.in_addr;
  assign din[1]  = port_b.in_din;

  if ((1 << AW) == p_RAM_DEPTH) begin : g_pow2
    assign in_range = 2'b11;
  end else begin : g_npow2
    for (genvar p = 0; p < 2; p++) begin : g_rng
      assign in_range[p] = (int'(addr[p]) < p_RAM_DEPTH);
    end
  end

  // An access refreshes dout unless it is a write in no-change mode.
  for (genvar p = 0; p < 2; p++) begin : g_upd
    assign updates[p] = en[p] && ((we[p] == '0) || (p_WRITE_MODE != MODE_NO_CHANGE));
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane
    // NOTE: memory contents are never reset; only the declaration gives them a value at time 0.
    (* ram_style = "block" *) logic [BW-1:0] lane_mem [p_RAM_DEPTH] = '{default: '0};

    // Port B is written first so port A's byte lands last and wins a same-address collision.
    // NOTE: non-blocking writes keep both ports' same-edge reads on the pre-write contents.
    always_ff @(posedge i_clk) begin
      if (i_rstn) begin
        if (en[1] && we[1][k] && in_range[1]) lane_mem[addr[1]] <= din[1][k*BW +: BW];
        if (en[0] && we[0][k] && in_range[0]) lane_mem[addr[0]] <= din[0][k*BW +: BW];
      end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
      logic [BW-1:0] rd_q;

      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          rd_q <= '0;
        end else if (updates[p] && in_range[p]) begin
          if ((p_WRITE_MODE == MODE_WRITE_FIRST) && we[p][k]) rd_q <= din[p][k*BW +: BW];
          else                                                 rd_q <= lane_mem[addr[p]];
        end
      end

      assign dout_q[p][k*BW +: BW] = rd_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) valid_q <= '0;
    else         valid_q <= updates;
  end

`ifdef BRAM_DP_OUTREG_EN
  logic [1:0][p_RAM_WIDTH-1:0] dout_r;
  logic [1:0]                  valid_r;

  // Loaded only behind a stage-1 valid so dout keeps holding between accesses.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      dout_r  <= '0;
      valid_r <= '0;
    end else begin
      valid_r <= valid_q;
      for (int p = 0; p < 2; p++) begin
        if (valid_q[p]) dout_r[p] <= dout_q[p];
      end
    end
  end

  assign port_a.on_dout = dout_r[0];
  assign port_a.o_valid = valid_r[0];
  assign port_b.on_dout = dout_r[1];
  assign port_b.o_valid = valid_r[1];
`else
  assign port_a.on_dout = dout_q[0];
  assign port_a.o_valid = valid_q[0];
  assign port_b.on_dout = dout_q[1];
  assign port_b.o_valid = valid_q[1];
`endif

  logic unused_modes;
  assign unused_modes = (MODE_READ_FIRST == 1);
endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: drives three bram_dp instances (write-first, read-first, no-change) with the same
// stimulus and compares every port against a behavioural model of memory plus a latency delay line.
module tb_bram_dp;
  localparam int W     = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef BRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic i_clk = 1'b0;
  logic i_rstn;
  logic          en   [2];
  logic [NB-1:0] we   [2];
  logic [AW-1:0] addr [2];
  logic [W-1:0]  din  [2];

  logic [2:0][1:0][W-1:0] dout_w;
  logic [2:0][1:0]        valid_w;

  int   checks = 0;
  int   errors = 0;
  logic cmp_on = 1'b0;

  always #5 i_clk = ~i_clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    bram_dp_if #(.p_RAM_WIDTH(W), .p_RAM_DEPTH(DEPTH), .p_BYTE_WIDTH(8)) port_a ();
    bram_dp_if #(.p_RAM_WIDTH(W), .p_RAM_DEPTH(DEPTH), .p_BYTE_WIDTH(8)) port_b ();

    assign port_a.i_en    = en[0];
    assign port_a.in_we   = we[0];
    assign port_a.in_addr = addr[0];
    assign port_a.in_din  = din[0];
    assign port_b.i_en    = en[1];
    assign port_b.in_we   = we[1];
    assign port_b.in_addr = addr[1];
    assign port_b.in_din  = din[1];
    assign dout_w[m][0]   = port_a.on_dout;
    assign valid_w[m][0]  = port_a.o_valid;
    assign dout_w[m][1]   = port_b.on_dout;
    assign valid_w[m][1]  = port_b.o_valid;

    bram_dp #(
      .p_RAM_WIDTH(W), .p_RAM_DEPTH(DEPTH), .p_BYTE_WIDTH(8), .p_WRITE_MODE(m)
    ) dut (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .port_a(port_a),
      .port_b(port_b)
    );
  end

  // Model: contents, plus per mode/port a LAT-deep line of access results and the held dout.
  logic [W-1:0] model_mem [DEPTH];
  logic         pv [3][2][LAT];
  logic [W-1:0] pd [3][2][LAT];
  logic         exp_valid [3][2];
  logic [W-1:0] exp_dout  [3][2];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                         input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    return r;
  endfunction

  // Applies the effect of the clock edge that just sampled the current inputs.
  task automatic model_step();
    logic         rv;
    logic [W-1:0] rd;
    if (!i_rstn) begin
      for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
        exp_valid[m][p] = 1'b0;
        exp_dout[m][p]  = '0;
        for (int s = 0; s < LAT; s++) begin pv[m][p][s] = 1'b0; pd[m][p][s] = '0; end
      end
      return;
    end
    for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
      rv = 1'b0;
      rd = '0;
      if (en[p]) begin
        if (we[p] == '0)  begin rv = 1'b1; rd = model_mem[addr[p]]; end
        else if (m == 0)  begin rv = 1'b1; rd = merge(model_mem[addr[p]], din[p], we[p]); end
        else if (m == 1)  begin rv = 1'b1; rd = model_mem[addr[p]]; end
      end
      for (int s = LAT - 1; s > 0; s--) begin
        pv[m][p][s] = pv[m][p][s-1];
        pd[m][p][s] = pd[m][p][s-1];
      end
      pv[m][p][0] = rv;
      pd[m][p][0] = rd;
      exp_valid[m][p] = pv[m][p][LAT-1];
      if (pv[m][p][LAT-1]) exp_dout[m][p] = pd[m][p][LAT-1];
    end
    for (int k = 0; k < NB; k++) begin
      if (en[1] && we[1][k]) model_mem[addr[1]][k*8 +: 8] = din[1][k*8 +: 8];
      if (en[0] && we[0][k]) model_mem[addr[0]][k*8 +: 8] = din[0][k*8 +: 8];
    end
  endtask

  task automatic cyc(input logic r,
                     input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [W-1:0] da,
                     input logic eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [W-1:0] db);
    i_rstn  = r;
    en[0] = ea; we[0] = wa; addr[0] = aa; din[0] = da;
    en[1] = eb; we[1] = wb; addr[1] = ab; din[1] = db;
    @(posedge i_clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
  endtask

  // Advances so the most recent access is visible at the outputs.
  task automatic settle();
    for (int i = 1; i < LAT; i++) idle();
  endtask

  always @(negedge i_clk) begin
    if (cmp_on) begin
      for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
        check($sformatf("valid m%0d p%0d", m, p), {31'b0, valid_w[m][p]}, {31'b0, exp_valid[m][p]});
        check($sformatf("dout m%0d p%0d", m, p), dout_w[m][p], exp_dout[m][p]);
      end
    end
  end

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
      exp_valid[m][p] = 1'b0;
      exp_dout[m][p]  = '0;
      for (int s = 0; s < LAT; s++) begin pv[m][p][s] = 1'b0; pd[m][p][s] = '0; end
    end

    // Reset
    cyc(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    cmp_on = 1'b1;
    cyc(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
      check("reset_dout", dout_w[m][p], '0);
      check("reset_valid", {31'b0, valid_w[m][p]}, '0);
    end

    // Basic write on A, cross-port read on B, unwritten address
    cyc(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 4'h0, '0, '0);
    cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'h0, 10'd5, '0);
    settle();
    for (int m = 0; m < 3; m++) begin
      check("basic_read_b", dout_w[m][1], 32'hDEADBEEF);
      check("basic_valid_b", {31'b0, valid_w[m][1]}, 32'd1);
    end
    cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'h0, 10'd6, '0);
    settle();
    check("unwritten_read", dout_w[0][1], '0);

    // Byte enables
    cyc(1'b1, 1'b1, 4'hF, 10'd10, 32'hAABBCCDD, 1'b0, 4'h0, '0, '0);
    cyc(1'b1, 1'b1, 4'b0101, 10'd10, 32'h11223344, 1'b0, 4'h0, '0, '0);
    cyc(1'b1, 1'b1, 4'h0, 10'd10, '0, 1'b0, 4'h0, '0, '0);
    settle();
    for (int m = 0; m < 3; m++) check("byte_enable", dout_w[m][0], 32'hAA22CC44);

    // Write modes: address 20 holds 0, port A's previous dout is 0xAA22CC44
    cyc(1'b1, 1'b1, 4'hF, 10'd20, 32'h55, 1'b0, 4'h0, '0, '0);
    settle();
    check("wf_dout", dout_w[0][0], 32'h55);
    check("wf_valid", {31'b0, valid_w[0][0]}, 32'd1);
    check("rf_dout", dout_w[1][0], 32'h0);
    check("rf_valid", {31'b0, valid_w[1][0]}, 32'd1);
    check("nc_dout", dout_w[2][0], 32'hAA22CC44);
    check("nc_valid", {31'b0, valid_w[2][0]}, 32'd0);

    // Write collision on address 9
    cyc(1'b1, 1'b1, 4'b1100, 10'd9, 32'hFFFF0000, 1'b1, 4'hF, 10'd9, 32'h12345678);
    cyc(1'b1, 1'b1, 4'h0, 10'd9, '0, 1'b0, 4'h0, '0, '0);
    settle();
    for (int m = 0; m < 3; m++) check("collision", dout_w[m][0], 32'hFFFF5678);

    // Cross-port read during write
    cyc(1'b1, 1'b1, 4'hF, 10'd3, 32'h1, 1'b0, 4'h0, '0, '0);
    cyc(1'b1, 1'b1, 4'hF, 10'd3, 32'h2, 1'b1, 4'h0, 10'd3, '0);
    settle();
    for (int m = 0; m < 3; m++) check("rdw_old", dout_w[m][1], 32'h1);
    cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'h0, 10'd3, '0);
    settle();
    for (int m = 0; m < 3; m++) check("rdw_new", dout_w[m][1], 32'h2);

    // Reset mid-stream during a write to address 7
    cyc(1'b1, 1'b1, 4'hF, 10'd7, 32'h77, 1'b0, 4'h0, '0, '0);
    cyc(1'b1, 1'b1, 4'h0, 10'd5, '0, 1'b1, 4'h0, 10'd9, '0);
    cyc(1'b1, 1'b1, 4'h0, 10'd5, '0, 1'b1, 4'h0, 10'd9, '0);
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b1, 4'hF, 10'd7, 32'h0BAD, 1'b1, 4'h0, 10'd9, '0);
      for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) begin
        check("midreset_dout", dout_w[m][p], '0);
        check("midreset_valid", {31'b0, valid_w[m][p]}, '0);
      end
    end
    cyc(1'b1, 1'b1, 4'h0, 10'd7, '0, 1'b1, 4'h0, 10'd5, '0);
    settle();
    for (int m = 0; m < 3; m++) begin
      check("after_reset_a", dout_w[m][0], 32'h77);
      check("after_reset_b", dout_w[m][1], 32'hDEADBEEF);
      check("after_reset_valid", {31'b0, valid_w[m][0]}, 32'd1);
    end

    // Random traffic on a small address window to provoke collisions and read-during-write
    repeat (3000) begin
      logic       r, ea, eb;
      logic [3:0] wa, wb;
      r  = ($urandom_range(0, 49) != 0);
      ea = ($urandom_range(0, 9) < 7);
      eb = ($urandom_range(0, 9) < 7);
      wa = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      wb = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      cyc(r, ea, wa, 10'($urandom_range(0, 15)), $urandom,
             eb, wb, 10'($urandom_range(0, 15)), $urandom);
    end
    idle();
    idle();
    @(negedge i_clk);
    #1;
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
